// File: rtl/coo_pkg.sv
// coo_pkg: entry and state types shared by the COO stream memory.
// Entry field widths track the default node count and weight width.
package coo_pkg;
    localparam int COO_NUM_NODES = 6;
    localparam int COO_VAL_BW = 8;
    localparam int COO_IDX_BW = $clog2(COO_NUM_NODES);

    typedef struct packed {
        logic [COO_IDX_BW-1:0] row;
        logic [COO_IDX_BW-1:0] col;
        logic [COO_VAL_BW-1:0] val;
    } coo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } coo_state_e;
endpackage

// File: rtl/coo_entry_ram.sv
// coo_entry_ram: 1W/1R entry store with a registered read port.
// A same-cycle write to the read address is forwarded to the read data.
module coo_entry_ram
    import coo_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  coo_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output coo_entry_t    rdata
);
    coo_entry_t mem [2**AW];
    coo_entry_t rdata_q;
    coo_entry_t rdata_d;

    always_comb begin
        rdata_d = mem[raddr];
        if (we && (waddr == raddr)) begin
            rdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/coo_stream_mem.sv
// coo_stream_mem: append-only COO edge table streamed out over valid/ready.
// The RAM always prefetches the entry after the one held on out_*.
module coo_stream_mem
    import coo_pkg::*;
#(
    parameter int NUM_NODES = COO_NUM_NODES,
    parameter int MAX_NNZ = 64,
    parameter int VAL_BW = COO_VAL_BW,
    parameter int IDX_BW = $clog2(NUM_NODES),
    parameter int CNT_BW = $clog2(MAX_NNZ + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_BW-1:0] wr_row,
    input  logic [IDX_BW-1:0] wr_col,
    input  logic [VAL_BW-1:0] wr_val,
    output logic              full,
    output logic              overflow,
    output logic [CNT_BW-1:0] nnz_count,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_BW-1:0] out_row,
    output logic [IDX_BW-1:0] out_col,
    output logic [VAL_BW-1:0] out_val,
    output logic              out_last,
    output logic              done
);
    localparam int AW = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;

    coo_state_e        state_q, state_d;
    logic [CNT_BW-1:0] nnz_q, nnz_d;
    logic [CNT_BW-1:0] idx_q, idx_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    coo_entry_t        out_q, out_d;
    coo_entry_t        rd_ent, wr_ent;
    logic              we;
    logic [AW-1:0]     raddr, waddr;
    logic [CNT_BW-1:0] idx_nxt;

    assign full    = (nnz_q == CNT_BW'(MAX_NNZ));
    assign idx_nxt = idx_q + CNT_BW'(1);
    assign waddr   = AW'(nnz_q);
    assign wr_ent  = '{row: wr_row, col: wr_col, val: wr_val};

    always_comb begin
        state_d     = state_q;
        nnz_d       = nnz_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_d       = out_q;
        we          = 1'b0;
        raddr       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    nnz_d = '0;
                    ovf_d = 1'b0;
                end else if (start) begin
                    if (wr_en) begin
                        ovf_d = 1'b1;
                    end
                    if (nnz_q != '0) begin
                        state_d     = ST_STREAM;
                        idx_d       = '0;
                        out_d       = rd_ent;
                        out_valid_d = 1'b1;
                        out_last_d  = (nnz_q == CNT_BW'(1));
                        raddr       = AW'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (wr_en) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we    = 1'b1;
                        nnz_d = nnz_q + CNT_BW'(1);
                    end
                end
            end
            ST_STREAM: begin
                raddr = AW'(idx_nxt);
                if (wr_en) begin
                    ovf_d = 1'b1;
                end
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_nxt;
                        out_d      = rd_ent;
                        out_last_d = (idx_nxt == nnz_q - CNT_BW'(1));
                        raddr      = AW'(idx_nxt + CNT_BW'(1));
                    end
                end
            end
            ST_DONE: begin
                if (wr_en) begin
                    ovf_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            nnz_q       <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            nnz_q       <= nnz_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_q       <= out_d;
        end
    end

    coo_entry_ram #(
        .DEPTH(MAX_NNZ),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wr_ent),
        .raddr(raddr),
        .rdata(rd_ent)
    );

    assign nnz_count = nnz_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == ST_STREAM);
    assign done      = (state_q == ST_DONE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_row   = out_q.row;
    assign out_col   = out_q.col;
    assign out_val   = out_q.val;
endmodule

// File: tb/tb_coo_stream_mem.sv
// tb_coo_stream_mem: directed scenarios plus random traffic,
// checked every cycle against a table-level reference model.
module tb_coo_stream_mem;
    localparam int NN = 6;
    localparam int MAXN = 4;
    localparam int VB = 8;
    localparam int IB = $clog2(NN);
    localparam int CB = $clog2(MAXN + 1);

    logic          clk = 1'b0;
    logic          reset, clear, wr_en, start, out_ready;
    logic [IB-1:0] wr_row, wr_col, out_row, out_col;
    logic [VB-1:0] wr_val, out_val;
    logic          full, overflow, busy, out_valid, out_last, done;
    logic [CB-1:0] nnz_count;

    int vectors = 0;
    int miscompares = 0;

    coo_stream_mem #(
        .NUM_NODES(NN),
        .MAX_NNZ  (MAXN),
        .VAL_BW   (VB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_val   (wr_val),
        .full     (full),
        .overflow (overflow),
        .nnz_count(nnz_count),
        .start    (start),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_val  (out_val),
        .out_last (out_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model: a list of stored edges plus a mode and cursor.
    int   m_row [MAXN];
    int   m_col [MAXN];
    int   m_val [MAXN];
    int   m_cnt = 0;
    int   m_k = 0;
    int   m_mode = 0;
    bit   m_ovf = 0;
    bit   m_zero = 0;
    bit   m_live = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_mode <= 0;
            m_cnt  <= 0;
            m_k    <= 0;
            m_ovf  <= 0;
            m_zero <= 1;
            m_live <= 1;
        end else if (m_live) begin
            if (m_mode == 0) begin
                if (clear) begin
                    m_cnt <= 0;
                    m_ovf <= 0;
                end else if (start) begin
                    if (wr_en) m_ovf <= 1;
                    if (m_cnt > 0) begin
                        m_mode <= 1;
                        m_k    <= 0;
                        m_zero <= 0;
                    end else begin
                        m_mode <= 2;
                    end
                end else if (wr_en) begin
                    if (m_cnt == MAXN) begin
                        m_ovf <= 1;
                    end else begin
                        m_row[m_cnt] <= int'(wr_row);
                        m_col[m_cnt] <= int'(wr_col);
                        m_val[m_cnt] <= int'(wr_val);
                        m_cnt <= m_cnt + 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (wr_en) m_ovf <= 1;
                if (out_ready) begin
                    if (m_k == m_cnt - 1) m_mode <= 2;
                    else m_k <= m_k + 1;
                end
            end else begin
                if (wr_en) m_ovf <= 1;
                m_mode <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("nnz", 32'(nnz_count), 32'(m_cnt));
            check("full", 32'(full), 32'(m_cnt == MAXN));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("busy", 32'(busy), 32'(m_mode == 1));
            check("done", 32'(done), 32'(m_mode == 2));
            check("out_valid", 32'(out_valid), 32'(m_mode == 1));
            check("out_last", 32'(out_last),
                  32'(m_mode == 1 && m_k == m_cnt - 1));
            if (m_mode == 1) begin
                check("out_row", 32'(out_row), 32'(m_row[m_k]));
                check("out_col", 32'(out_col), 32'(m_col[m_k]));
                check("out_val", 32'(out_val), 32'(m_val[m_k]));
            end else if (m_zero) begin
                check("out_zero", 32'({out_row, out_col, out_val}), 0);
            end
        end
    end

    int er [3] = '{0, 2, 4};
    int ec [3] = '{1, 3, 5};
    int ev [3] = '{5, 7, 9};
    int rp [5] = '{1, 0, 0, 1, 1};
    int ei [5] = '{0, 1, 1, 1, 2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input int v);
        wr_en  = 1'b1;
        wr_row = IB'(r);
        wr_col = IB'(c);
        wr_val = VB'(v);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wr3();
        for (int i = 0; i < 3; i++) wr(er[i], ec[i], ev[i]);
    endtask

    task automatic chk_ent(input string name, input int i, input bit last);
        check({name, ".valid"}, 32'(out_valid), 1);
        check({name, ".row"}, 32'(out_row), 32'(er[i]));
        check({name, ".col"}, 32'(out_col), 32'(ec[i]));
        check({name, ".val"}, 32'(out_val), 32'(ev[i]));
        check({name, ".last"}, 32'(out_last), 32'(last));
    endtask

    initial begin
        int hs;
        reset = 1'b0;
        clear = 1'b0;
        wr_en = 1'b0;
        wr_row = '0;
        wr_col = '0;
        wr_val = '0;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        check("rst.valid", 32'(out_valid), 0);
        check("rst.nnz", 32'(nnz_count), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.out", 32'({out_row, out_col, out_val}), 0);

        wr3();
        check("wr.nnz", 32'(nnz_count), 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        chk_ent("burst0", 0, 0);
        tick();
        chk_ent("burst1", 1, 0);
        tick();
        chk_ent("burst2", 2, 1);
        tick();
        check("burst.done", 32'(done), 1);
        check("burst.valid", 32'(out_valid), 0);
        tick();
        check("burst.done_off", 32'(done), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            out_ready = rp[i][0];
            chk_ent("stall", ei[i], ei[i] == 2);
            if (out_valid && out_ready) hs++;
            tick();
        end
        check("stall.done", 32'(done), 1);
        check("stall.hs", 32'(hs), 3);
        out_ready = 1'b0;
        tick();

        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) wr(i, 5 - i, 16 + i);
        check("ovf.nnz", 32'(nnz_count), 4);
        check("ovf.full", 32'(full), 1);
        check("ovf.flag", 32'(overflow), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr.nnz", 32'(nnz_count), 0);
        check("clr.flag", 32'(overflow), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty.valid", 32'(out_valid), 0);
        check("empty.done", 32'(done), 1);
        tick();
        check("empty.done_off", 32'(done), 0);

        wr3();
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort.valid", 32'(out_valid), 0);
        check("abort.nnz", 32'(nnz_count), 0);
        check("abort.done", 32'(done), 0);
        check("abort.row", 32'(out_row), 0);
        tick();
        check("abort.done2", 32'(done), 0);

        wr3();
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1;
        wr_row = 3'd1;
        wr_col = 3'd1;
        wr_val = 8'hAA;
        chk_ent("swr0", 0, 0);
        tick();
        check("swr.nnz", 32'(nnz_count), 3);
        check("swr.ovf", 32'(overflow), 1);
        chk_ent("swr1", 1, 0);
        tick();
        chk_ent("swr2", 2, 1);
        tick();
        wr_en = 1'b0;
        check("swr.done", 32'(done), 1);
        tick();

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            wr_en = $urandom_range(0, 1) == 1;
            wr_row = IB'($urandom_range(0, NN - 1));
            wr_col = IB'($urandom_range(0, NN - 1));
            wr_val = VB'($urandom);
            start = ($urandom_range(0, 11) == 0);
            clear = ($urandom_range(0, 15) == 0) && !start;
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end
endmodule

// File: doc/coo_stream_mem.md
COO_STREAM_MEM -- requirements
Module: coo_stream_mem

Interface
REQ-001 SHALL have parameter NUM_NODES, default 6, meaning graph node count; row/col indices range 0..NUM_NODES-1.
REQ-002 SHALL have parameter MAX_NNZ, default 64, meaning maximum stored nonzero edges.
REQ-003 SHALL have parameter VAL_BW, default 8, meaning edge-weight width.
REQ-004 SHALL have derived parameter IDX_BW, default $clog2(NUM_NODES), meaning index width.
REQ-005 SHALL have derived parameter CNT_BW, default $clog2(MAX_NNZ+1), meaning count width.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous active-low reset (0 = reset).
REQ-008 SHALL have port clear  input  1  synchronous table clear.
REQ-009 SHALL have ports wr_en input 1, wr_row input IDX_BW, wr_col input IDX_BW, wr_val input VAL_BW  append one COO entry.
REQ-010 SHALL have ports full output 1 and overflow output 1  table full; sticky dropped-write flag.
REQ-011 SHALL have port nnz_count  output  CNT_BW  number of stored entries.
REQ-012 SHALL have ports start input 1 and busy output 1  begin a stream; stream in progress.
REQ-013 SHALL have ports out_valid output 1, out_ready input 1  output handshake.
REQ-014 SHALL have ports out_row output IDX_BW, out_col output IDX_BW, out_val output VAL_BW, out_last output 1  current entry; final-entry marker.
REQ-015 SHALL have port done  output  1  one-cycle end-of-stream pulse.

Function
REQ-016 SHALL store entries in insertion order at address nnz_count, then increment nnz_count, when wr_en=1, state IDLE and full=0.
REQ-017 SHALL assert full combinationally when nnz_count==MAX_NNZ.
REQ-018 SHALL drop wr_en while full=1 or state!=IDLE, and set overflow=1 until reset or clear.
REQ-019 SHALL, on clear=1 in IDLE, set nnz_count=0 and overflow=0 next cycle; memory contents are not cleared; clear has priority over a simultaneous wr_en.
REQ-020 SHALL ignore clear and start outside IDLE.
REQ-021 SHALL implement FSM IDLE -> STREAM -> DONE -> IDLE; busy=1 in STREAM.
REQ-022 SHALL, on start=1 in IDLE with nnz_count>0, enter STREAM next cycle with out_valid=1 and entry 0 on out_* (latency 1).
REQ-023 SHALL, on start=1 in IDLE with nnz_count==0, go directly to DONE; out_valid stays 0.
REQ-024 SHALL give start priority over simultaneous wr_en in IDLE; that write is dropped and overflow set.
REQ-025 SHALL hold out_* and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on handshake (out_valid&out_ready), present entry k+1 the following cycle with no bubble, sustaining one entry per cycle at out_ready=1.
REQ-027 SHALL assert out_last=1 exactly with entry nnz_count-1; its handshake moves to DONE with out_valid=0.
REQ-028 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL drive out_* from registers, never directly from an unregistered memory read.

Reset
REQ-030 SHALL, while reset=0 at a clock edge, force state IDLE, nnz_count=0, overflow=0, out_valid=0, out_last=0, done=0, busy=0, out_row/out_col/out_val=0.
REQ-031 SHALL abort a stream on mid-operation reset with no done pulse; memory array contents are not reset.

Structure
REQ-032 SHALL import a shared package coo_pkg holding the coo_entry_t struct (row, col, val) and the FSM state enum.
REQ-033 SHALL place storage in one sub-module coo_entry_ram (1 write, 1 synchronous read port, no reset).

Verification
REQ-034 SHALL cover: reset, write (0,1,5),(2,3,7),(4,5,9), start, out_ready=1 -> entries on 3 consecutive cycles, out_last with (4,5,9), done next cycle.
REQ-035 SHALL cover: same 3 entries, out_ready toggling 1,0,0,1,1 -> each entry held stable while stalled, exactly 3 handshakes, order preserved.
REQ-036 SHALL cover: MAX_NNZ=4, 5 writes -> nnz_count=4, full=1, overflow=1; clear -> nnz_count=0, overflow=0.
REQ-037 SHALL cover: start with nnz_count=0 -> no out_valid, done one cycle later.
REQ-038 SHALL cover: reset=0 asserted after second handshake of 3 -> next cycle out_valid=0, nnz_count=0, no done.
REQ-039 SHALL cover: wr_en during STREAM -> nnz_count unchanged, overflow=1, stream output unaffected.
